// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M/RV64M multiply-divide unit:
// func3 codes, FSM state encoding and operation decode helpers.
package muldiv_pkg;

  localparam logic [2:0] FN_MUL    = 3'b000;
  localparam logic [2:0] FN_MULH   = 3'b001;
  localparam logic [2:0] FN_MULHSU = 3'b010;
  localparam logic [2:0] FN_MULHU  = 3'b011;
  localparam logic [2:0] FN_DIV    = 3'b100;
  localparam logic [2:0] FN_DIVU   = 3'b101;
  localparam logic [2:0] FN_REM    = 3'b110;
  localparam logic [2:0] FN_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_div(input logic [2:0] f);
    return f[2];
  endfunction

  function automatic logic is_rem(input logic [2:0] f);
    return f[2] & f[1];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] f);
    return (f != FN_MULHU) && (f != FN_DIVU) && (f != FN_REMU);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] f);
    return is_signed_a(f) && (f != FN_MULHSU);
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negation of a parametrised-width value.
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? ('0 - din) : din;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide
// on operand magnitudes, sign fix-up afterwards, valid/ready on both sides.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       func3,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state;
  logic [2:0]        func3_r;
  logic              neg_res;
  logic              neg_rem;
  logic [XLEN-1:0]   mag_b;
  logic [2*XLEN-1:0] acc;
  logic [CNT_W-1:0]  count;

  logic              fire;
  logic              sign_a, sign_b;
  logic [XLEN-1:0]   mag_a_in, mag_b_in;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   fast_result;

  assign in_ready = (state == ST_IDLE);
  assign fire     = in_valid & in_ready & ~flush;

  assign sign_a = is_signed_a(func3) & op_a[XLEN-1];
  assign sign_b = is_signed_b(func3) & op_b[XLEN-1];

  muldiv_negate #(.W(XLEN)) u_neg_a (.neg(sign_a), .din(op_a), .dout(mag_a_in));
  muldiv_negate #(.W(XLEN)) u_neg_b (.neg(sign_b), .din(op_b), .dout(mag_b_in));

  // Divide corner cases resolve at acceptance and skip the iteration.
  assign div_zero = is_div(func3) & (op_b == '0);
  assign div_ovf  = is_div(func3) & is_signed_a(func3) & (op_a == MOST_NEG) & (&op_b);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
    fast_result = op_a;
    if (div_zero)
      fast_result = is_rem(func3) ? op_a : '1;
    else if (is_rem(func3))
      fast_result = '0;
  end

  // Single shared XLEN+1 adder: accumulate for multiply, trial subtract for divide.
  logic              div_op;
  logic [XLEN-1:0]   acc_hi, acc_lo;
  logic [XLEN:0]     add_a, add_b, sum;
  logic [2*XLEN-1:0] step_acc;

  assign div_op = is_div(func3_r);
  assign acc_hi = acc[2*XLEN-1:XLEN];
  assign acc_lo = acc[XLEN-1:0];
  assign add_a  = div_op ? {acc_hi, acc_lo[XLEN-1]} : {1'b0, acc_hi};
  assign add_b  = {1'b0, mag_b};
  assign sum    = add_a + (div_op ? ~add_b : add_b) + {{XLEN{1'b0}}, div_op};

  always_comb begin
    step_acc = acc;
    if (div_op) begin
      if (!sum[XLEN])
        step_acc = {sum[XLEN-1:0], acc_lo[XLEN-2:0], 1'b1};
      else
        step_acc = {add_a[XLEN-1:0], acc_lo[XLEN-2:0], 1'b0};
    end else if (acc_lo[0]) begin
      step_acc = {sum, acc_lo[XLEN-1:1]};
    end else begin
      step_acc = {1'b0, acc_hi, acc_lo[XLEN-1:1]};
    end
  end

  // Negation is applied to the full product so the high half sees the carry.
  logic [2*XLEN-1:0] fix_in, fix_out;
  logic              fix_neg;
  logic [XLEN-1:0]   fix_result;

  assign fix_in  = div_op ? {{XLEN{1'b0}}, (is_rem(func3_r) ? acc_hi : acc_lo)} : acc;
  assign fix_neg = is_rem(func3_r) ? neg_rem : neg_res;

  muldiv_negate #(.W(2*XLEN)) u_neg_fix (.neg(fix_neg), .din(fix_in), .dout(fix_out));

  assign fix_result = (!div_op && func3_r != FN_MUL) ? fix_out[2*XLEN-1:XLEN]
                                                    : fix_out[XLEN-1:0];

  // NOTE: datapath registers are always loaded on acceptance before they are read, so they carry no reset.
  always_ff @(posedge clk) begin
    if (fire) begin
      func3_r <= func3;
      neg_res <= sign_a ^ sign_b;
      neg_rem <= sign_a;
      mag_b   <= mag_b_in;
      acc     <= {{XLEN{1'b0}}, mag_a_in};
      count   <= '0;
    end else if (state == ST_CALC) begin
      acc   <= step_acc;
      count <= count + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      out_tag   <= '0;
    end else if (flush) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (fire) begin
            out_tag <= in_tag;
            if (div_zero || div_ovf) begin
              result    <= fast_result;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end else begin
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (count == LAST_STEP)
            state <= ST_FIX;
        end
        ST_FIX: begin
          result    <= fix_result;
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=32): all eight ops,
// fast paths, latency, flush/reset abort and output back-pressure.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  func3;
  logic [31:0] op_a, op_b;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  out_tag;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .func3    (func3),
    .op_a     (op_a),
    .op_b     (op_b),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .out_tag  (out_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed time %0t required end before it", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, wait (bounded) for out_valid, capture, then handshake.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, output logic [31:0] res,
                        output logic [4:0] otag, output int lat);
    int t;
    @(negedge clk);
    func3 = f; op_a = a; op_b = b; in_tag = tag; in_valid = 1'b1;
    t = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin
        lat = cyc - t;
        break;
      end
      @(negedge clk);
    end
    res  = result;
    otag = out_tag;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [31:0] res;
  logic [4:0]  otag;
  int          lat;
  int          t0;
  logic        seen_valid;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    func3 = '0; op_a = '0; op_b = '0; in_tag = '0;
    #12;
    check("reset_in_ready",  in_ready,  1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_result",    result,    32'h0);
    check("reset_out_tag",   out_tag,   5'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(FN_MUL, 32'd7, 32'hFFFF_FFFD, 5'h1A, res, otag, lat);
    check("mul_result",  res,  32'hFFFF_FFEB);
    check("mul_tag",     otag, 5'h1A);
    check("mul_latency", lat,  34);

    run_op(FN_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h01, res, otag, lat);
    check("mulhu_result", res, 32'hFFFF_FFFE);
    run_op(FN_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h02, res, otag, lat);
    check("mulh_result", res, 32'h0000_0000);
    run_op(FN_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h03, res, otag, lat);
    check("mulhsu_result", res, 32'hFFFF_FFFF);

    run_op(FN_DIV, 32'hFFFF_FFF9, 32'd2, 5'h04, res, otag, lat);
    check("div_result",  res, 32'hFFFF_FFFD);
    check("div_latency", lat, 34);
    run_op(FN_REM, 32'hFFFF_FFF9, 32'd2, 5'h05, res, otag, lat);
    check("rem_result", res, 32'hFFFF_FFFF);
    run_op(FN_DIVU, 32'd100, 32'd7, 5'h06, res, otag, lat);
    check("divu_result", res, 32'd14);
    run_op(FN_REMU, 32'd100, 32'd7, 5'h07, res, otag, lat);
    check("remu_result", res, 32'd2);

    run_op(FN_DIVU, 32'h1234, 32'h0, 5'h08, res, otag, lat);
    check("divu_zero_result",  res,  32'hFFFF_FFFF);
    check("divu_zero_latency", lat,  1);
    check("divu_zero_tag",     otag, 5'h08);
    run_op(FN_REMU, 32'h1234, 32'h0, 5'h09, res, otag, lat);
    check("remu_zero_result", res, 32'h1234);
    run_op(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'h0A, res, otag, lat);
    check("div_ovf_result",  res, 32'h8000_0000);
    check("div_ovf_latency", lat, 1);
    run_op(FN_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'h0B, res, otag, lat);
    check("rem_ovf_result", res, 32'h0);

    // Flush at t+10 of a DIV.
    @(negedge clk);
    func3 = FN_DIV; op_a = 32'd1000; op_b = 32'd3; in_tag = 5'h0C; in_valid = 1'b1;
    t0 = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    while (cyc < t0 + 10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_in_ready",  in_ready,  1'b1);
    check("flush_out_valid", out_valid, 1'b0);
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen_valid |= out_valid;
      @(negedge clk);
    end
    check("flush_no_result", seen_valid, 1'b0);
    run_op(FN_MUL, 32'd12345, 32'd678, 5'h0D, res, otag, lat);
    check("after_flush_mul", res,  32'd8369910);
    check("after_flush_tag", otag, 5'h0D);

    // Reset pulse mid-CALC.
    run_op(FN_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 5'h0E, res, otag, lat);
    check("pre_reset_mulhu", res, 32'h0B00_EA4E);
    @(negedge clk);
    func3 = FN_DIVU; op_a = 32'd999; op_b = 32'd9; in_tag = 5'h0F; in_valid = 1'b1;
    t0 = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    while (cyc < t0 + 12) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result",    result,    32'h0);
    check("rst_out_tag",   out_tag,   5'h0);
    run_op(FN_MUL, 32'hFFFF_FFFF, 32'd5, 5'h10, res, otag, lat);
    check("after_rst_mul", res, 32'hFFFF_FFFB);

    // Back-pressure: out_ready low for 5 cycles in DONE.
    @(negedge clk);
    func3 = FN_DIVU; op_a = 32'd100; op_b = 32'd7; in_tag = 5'h13; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) break;
      @(negedge clk);
    end
    check("stall_reach_done", out_valid, 1'b1);
    func3 = FN_REMU; in_tag = 5'h14; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_hold", {out_valid, in_ready, out_tag, result},
            {1'b1, 1'b0, 5'h13, 32'd14});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_handshake_idle", {in_ready, out_valid}, 2'b10);
    @(negedge clk);
    in_valid = 1'b0;
    check("accept_after_handshake", in_ready, 1'b0);
    for (int i = 0; i < 100; i++) begin
      if (out_valid) break;
      @(negedge clk);
    end
    check("stall_next_result", {out_valid, out_tag, result}, {1'b1, 5'h14, 32'd2});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
